// File: rtl/cohort_noc_arb_pkg.sv
// Shared types and helpers for the cohort NoC2 request arbiter: request payload,
// MSHR id width and the round-robin pick function.
package cohort_noc_arb_pkg;

    localparam int MSHR_ID_W = 8;
    localparam int RR_W      = 3;

    typedef struct packed {
        logic [7:0]  req_type;
        logic [39:0] address;
        logic [2:0]  size;
        logic [7:0]  write_mask;
        logic [63:0] data_0;
        logic [63:0] data_1;
        logic        need_resp;
    } req_t;

    // Unused upper valid bits are zero, so scanning modulo 8 equals scanning modulo SRC_NUM.
    function automatic logic [RR_W-1:0] rr_pick(input logic [7:0] valid, input logic [RR_W-1:0] ptr);
        logic [RR_W-1:0] pick;
        logic [RR_W-1:0] idx;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx   = ptr + RR_W'(i);
            pick  = (valid[idx] && !found) ? idx : pick;
            found = found | valid[idx];
        end
        return pick;
    endfunction

endpackage

// File: rtl/cohort_mshr_pool.sv
// MSHR id pool: busy bitmap, lowest-free encoder, owner table and two release ports.
// Allocation reads the registered bitmap, so a released id is only offered from the next cycle.
module cohort_mshr_pool
    import cohort_noc_arb_pkg::*;
#(
    parameter  int MSHR_NUM = 4,
    localparam int IDX_W    = $clog2(MSHR_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_en,
    input  logic [RR_W-1:0]  alloc_owner,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             alloc_avail,
    input  logic             rel_a_en,
    input  logic [IDX_W-1:0] rel_a_idx,
    input  logic             rel_b_en,
    input  logic [IDX_W-1:0] rel_b_idx,
    input  logic [IDX_W-1:0] look_idx,
    output logic             look_busy,
    output logic [RR_W-1:0]  look_owner
);

    localparam logic [MSHR_NUM-1:0] LSB_ONE = {{(MSHR_NUM-1){1'b0}}, 1'b1};

    logic [MSHR_NUM-1:0] busy_r;
    logic [RR_W-1:0]     owner_r [MSHR_NUM];
    logic [IDX_W-1:0]    free_idx_s;
    logic                free_any_s;
    logic [MSHR_NUM-1:0] set_mask_s;
    logic [MSHR_NUM-1:0] clr_mask_s;

    // Lowest free index: scan from the top so the smallest free index wins.
    always_comb begin
        free_idx_s = '0;
        free_any_s = 1'b0;
        for (int k = MSHR_NUM - 1; k >= 0; k--) begin
            free_idx_s = busy_r[k] ? free_idx_s : IDX_W'(k);
            free_any_s = free_any_s | ~busy_r[k];
        end
    end

    // Set/clear masks for the bitmap update.
    always_comb begin
        set_mask_s = alloc_en ? (LSB_ONE << free_idx_s) : '0;
        clr_mask_s = (rel_a_en ? (LSB_ONE << rel_a_idx) : '0)
                   | (rel_b_en ? (LSB_ONE << rel_b_idx) : '0);
    end

    // Busy bitmap and owner table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
            for (int k = 0; k < MSHR_NUM; k++) begin
                owner_r[k] <= '0;
            end
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
            if (alloc_en) begin
                owner_r[free_idx_s] <= alloc_owner;
            end
        end
    end

    assign alloc_idx   = free_idx_s;
    assign alloc_avail = free_any_s;
    assign look_busy   = busy_r[look_idx];
    assign look_owner  = owner_r[look_idx];

endmodule

// File: rtl/cohort_noc_req_arbiter.sv
// Round-robin arbiter sharing the NoC2 request path, tagging grants with pool MSHR ids
// and routing NoC3 responses to their owner. Optional COHORT_NOC_ARB_PERF_EN adds perf counters.
module cohort_noc_req_arbiter
    import cohort_noc_arb_pkg::*;
#(
    parameter int SRC_NUM   = 3,
    parameter int MSHR_BASE = 128,
    parameter int MSHR_NUM  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SRC_NUM-1:0]   src_valid_i,
    output logic [SRC_NUM-1:0]   src_ready_o,
    input  req_t [SRC_NUM-1:0]   src_req_i,
    output logic                 sink_valid_o,
    input  logic                 sink_ready_i,
    output req_t                 sink_req_o,
    output logic [MSHR_ID_W-1:0] sink_mshrid_o,
    input  logic                 resp_valid_i,
    input  logic [MSHR_ID_W-1:0] resp_mshrid_i,
    input  logic [63:0]          resp_data_i,
    output logic [SRC_NUM-1:0]   src_resp_valid_o,
    output logic [63:0]          src_resp_data_o,
    output logic                 err_o
`ifdef COHORT_NOC_ARB_PERF_EN
    ,
    output logic [SRC_NUM*32-1:0] perf_grant_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    localparam int                   IDX_W   = $clog2(MSHR_NUM);
    localparam logic [MSHR_ID_W:0]   ID_LO   = (MSHR_ID_W+1)'(MSHR_BASE);
    localparam logic [MSHR_ID_W:0]   ID_HI   = (MSHR_ID_W+1)'(MSHR_BASE + MSHR_NUM);
    localparam logic [MSHR_ID_W-1:0] BASE_ID = MSHR_ID_W'(MSHR_BASE);

    logic [RR_W-1:0]      rr_ptr_r;
    logic                 sink_valid_r;
    req_t                 sink_req_r;
    logic [MSHR_ID_W-1:0] sink_mshrid_r;
    logic                 err_r;

    logic [RR_W-1:0]      winner_s;
    logic                 grant_s;
    req_t                 win_req_s;
    logic [SRC_NUM-1:0]   src_ready_s;
    logic [IDX_W-1:0]     alloc_idx_s;
    logic                 alloc_avail_s;
    logic                 rel_sink_s;
    logic [IDX_W-1:0]     sink_idx_s;
    logic                 resp_in_range_s;
    logic [IDX_W-1:0]     resp_idx_s;
    logic                 look_busy_s;
    logic [RR_W-1:0]      look_owner_s;
    logic                 resp_hit_s;
    logic [SRC_NUM-1:0]   resp_strobe_s;

    // Arbitration, grant decode and winner payload mux.
    always_comb begin
        winner_s    = rr_pick(8'(src_valid_i), rr_ptr_r);
        grant_s     = (|src_valid_i) && alloc_avail_s && (!sink_valid_r || sink_ready_i);
        src_ready_s = '0;
        win_req_s   = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            src_ready_s[i] = grant_s && (winner_s == RR_W'(i));
            win_req_s      = (winner_s == RR_W'(i)) ? src_req_i[i] : win_req_s;
        end
    end

    // Response decode and owner strobe; release of need_resp=0 ids on the sink handshake.
    always_comb begin
        resp_in_range_s = ({1'b0, resp_mshrid_i} >= ID_LO) && ({1'b0, resp_mshrid_i} < ID_HI);
        resp_idx_s      = IDX_W'(resp_mshrid_i - BASE_ID);
        resp_hit_s      = resp_valid_i && resp_in_range_s && look_busy_s;
        resp_strobe_s   = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            resp_strobe_s[i] = resp_hit_s && (look_owner_s == RR_W'(i));
        end
        rel_sink_s = sink_valid_r && sink_ready_i && !sink_req_r.need_resp;
        sink_idx_s = IDX_W'(sink_mshrid_r - BASE_ID);
    end

    cohort_mshr_pool #(
        .MSHR_NUM (MSHR_NUM)
    ) u_pool (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_en    (grant_s),
        .alloc_owner (winner_s),
        .alloc_idx   (alloc_idx_s),
        .alloc_avail (alloc_avail_s),
        .rel_a_en    (rel_sink_s),
        .rel_a_idx   (sink_idx_s),
        .rel_b_en    (resp_hit_s),
        .rel_b_idx   (resp_idx_s),
        .look_idx    (resp_idx_s),
        .look_busy   (look_busy_s),
        .look_owner  (look_owner_s)
    );

    // Round-robin pointer advances past the winner only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            rr_ptr_r <= (winner_s == RR_W'(SRC_NUM - 1)) ? '0 : winner_s + 3'd1;
        end
    end

    // Output register: loads on grant, holds under backpressure, drains on sink_ready_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sink_valid_r  <= 1'b0;
            sink_req_r    <= '0;
            sink_mshrid_r <= '0;
        end else if (grant_s) begin
            sink_valid_r  <= 1'b1;
            sink_req_r    <= win_req_s;
            sink_mshrid_r <= BASE_ID + MSHR_ID_W'(alloc_idx_s);
        end else if (sink_ready_i) begin
            sink_valid_r  <= 1'b0;
        end
    end

    // Sticky error on responses to out-of-range or unallocated ids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (resp_valid_i && !resp_hit_s) begin
            err_r <= 1'b1;
        end
    end

    assign src_ready_o      = src_ready_s;
    assign sink_valid_o     = sink_valid_r;
    assign sink_req_o       = sink_req_r;
    assign sink_mshrid_o    = sink_mshrid_r;
    assign src_resp_valid_o = resp_strobe_s;
    assign src_resp_data_o  = resp_hit_s ? resp_data_i : 64'd0;
    assign err_o            = err_r;

`ifdef COHORT_NOC_ARB_PERF_EN
    logic [31:0] grant_cnt_r [SRC_NUM];
    logic [31:0] stall_cnt_r;

    // Saturating per-requester grant counters and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SRC_NUM; i++) begin
                grant_cnt_r[i] <= 32'd0;
            end
            stall_cnt_r <= 32'd0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (src_ready_s[i] && (grant_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
                end
            end
            if ((|src_valid_i) && !grant_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    // Flatten the grant counters onto the output bus.
    always_comb begin
        perf_grant_cnt_o = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            perf_grant_cnt_o[i*32 +: 32] = grant_cnt_r[i];
        end
    end

    assign perf_stall_cnt_o = stall_cnt_r;
`endif

endmodule
